// File: rtl/uart_bus_parser_if.sv
// Signal bundle between the UART byte stream, the parser and the internal bus.
// The parser takes the master side; the UART/bus environment takes the slave side.
interface uart_bus_parser_if;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;
  logic        rx_overrun;

  modport master (
    input  rx_data, new_rx_data, tx_busy, int_rd_data, int_gnt,
    output tx_data, new_tx_data, int_address, int_wr_data,
           int_write, int_read, int_req, rx_overrun
  );

  modport slave (
    output rx_data, new_rx_data, tx_busy, int_rd_data, int_gnt,
    input  tx_data, new_tx_data, int_address, int_wr_data,
           int_write, int_read, int_req, rx_overrun
  );
endinterface

// File: rtl/uart_bus_parser.sv
// Turns UART command frames (CMD, ADDR_H, ADDR_L, LEN, [data]) into internal
// bus reads/writes, returning read bytes or an ACK byte over the UART.
module uart_bus_parser #(
  parameter logic [7:0] ACK_BYTE = 8'h5A
) (
  input logic               clock,
  input logic               reset,
  uart_bus_parser_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_WDATA, S_REQ,
    S_ACCESS, S_RCAP, S_TXWAIT, S_TXSEND, S_TXHOLD
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_isWrite;
  logic [15:0] r_address;
  logic [8:0]  r_count;
  logic [7:0]  r_wrData;
  logic [7:0]  r_txData;
  logic        r_overrun;
  logic        w_validCmd;
  logic        w_dropState;

  assign w_validCmd  = (bus.rx_data == 8'h01) || (bus.rx_data == 8'h02);
  assign w_dropState = r_state inside {S_REQ, S_ACCESS, S_RCAP, S_TXWAIT, S_TXSEND, S_TXHOLD};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (bus.new_rx_data && w_validCmd) w_nextState = S_ADDR_H;
      S_ADDR_H: if (bus.new_rx_data) w_nextState = S_ADDR_L;
      S_ADDR_L: if (bus.new_rx_data) w_nextState = S_LEN;
      S_LEN:    if (bus.new_rx_data) w_nextState = r_isWrite ? S_WDATA : S_REQ;
      S_WDATA:  if (bus.new_rx_data) w_nextState = S_REQ;
      S_REQ:    if (bus.int_gnt) w_nextState = S_ACCESS;
      // r_count still holds the pre-decrement value here, so 1 means last byte
      S_ACCESS: begin
        if (!r_isWrite)            w_nextState = S_RCAP;
        else if (r_count == 9'd1)  w_nextState = S_TXWAIT;
        else                       w_nextState = S_WDATA;
      end
      S_RCAP:   w_nextState = S_TXWAIT;
      S_TXWAIT: if (!bus.tx_busy) w_nextState = S_TXSEND;
      S_TXSEND: w_nextState = S_TXHOLD;
      S_TXHOLD: w_nextState = (!r_isWrite && (r_count != 9'd0)) ? S_REQ : S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_isWrite <= 1'b0;
      r_address <= 16'h0000;
      r_count   <= 9'd0;
      r_wrData  <= 8'h00;
      r_txData  <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= bus.new_rx_data && w_dropState;
      case (r_state)
        S_IDLE:   if (bus.new_rx_data && w_validCmd) r_isWrite <= (bus.rx_data == 8'h02);
        S_ADDR_H: if (bus.new_rx_data) r_address[15:8] <= bus.rx_data;
        S_ADDR_L: if (bus.new_rx_data) r_address[7:0] <= bus.rx_data;
        S_LEN: begin
          if (bus.new_rx_data) begin
            r_count <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          end
        end
        S_WDATA:  if (bus.new_rx_data) r_wrData <= bus.rx_data;
        S_ACCESS: begin
          r_address <= r_address + 16'd1;
          r_count   <= r_count - 9'd1;
          if (r_isWrite && (r_count == 9'd1)) r_txData <= ACK_BYTE;
        end
        S_RCAP:   r_txData <= bus.int_rd_data;
        default:  ;
      endcase
    end
  end

  assign bus.int_address = r_address;
  assign bus.int_wr_data = r_wrData;
  assign bus.tx_data     = r_txData;
  assign bus.int_req     = (r_state == S_REQ) || (r_state == S_ACCESS);
  assign bus.int_write   = (r_state == S_ACCESS) && r_isWrite;
  assign bus.int_read    = (r_state == S_ACCESS) && !r_isWrite;
  assign bus.new_tx_data = (r_state == S_TXSEND);
  assign bus.rx_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_bus_parser.sv
// Scoreboard bench: frames are issued from a byte-level reference model, and a
// separate monitor matches every bus strobe and UART transmit against it.
module tb_uart_bus_parser;
  localparam logic [7:0] ACK = 8'h5A;

  logic clock = 1'b0;
  logic reset;
  uart_bus_parser_if bus ();

  uart_bus_parser #(.ACK_BYTE(ACK)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [23:0] expWr[$];
  logic [15:0] expRdAddr[$];
  logic [7:0]  rdData[$];
  logic [7:0]  expTx[$];
  logic [7:0]  fixedQ[$];
  int expOvr = 0;
  int wrSeen = 0, rdSeen = 0, txSeen = 0, ovrSeen = 0;
  int totWr = 0, totRd = 0, totTx = 0;
  int gntMode = 0;
  bit latChk = 1'b0;
  bit busyForce = 1'b0;

  task automatic reportFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Grant and transmitter-busy models; busy is raised once a byte starts sending
  initial begin
    int busyLeft = 0;
    bus.int_gnt = 1'b1;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      case (gntMode)
        0:       bus.int_gnt = 1'b1;
        1:       bus.int_gnt = ($urandom_range(0, 2) != 0);
        default: bus.int_gnt = 1'b0;
      endcase
      if (bus.new_tx_data) busyLeft = $urandom_range(1, 6);
      if (busyForce || busyLeft > 0) begin
        bus.tx_busy = 1'b1;
        if (busyLeft > 0) busyLeft--;
      end else begin
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expectations as the DUT strobes, and answers reads
  initial begin
    int reqRun = 0;
    bit prevWr = 0, prevRd = 0, prevTx = 0, prevOvr = 0;
    logic [23:0] ew;
    bus.int_rd_data = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        reqRun = 0; prevWr = 0; prevRd = 0; prevTx = 0; prevOvr = 0;
        continue;
      end
      reqRun = bus.int_req ? reqRun + 1 : 0;
      if (bus.int_write) begin
        wrSeen++;
        if (expWr.size() == 0) reportFail("unexpectedWrite", {8'h00, bus.int_address, bus.int_wr_data}, 0);
        else begin
          ew = expWr.pop_front();
          checkOutput("writeAddr", 32'(bus.int_address), 32'(ew[23:8]));
          checkOutput("writeData", 32'(bus.int_wr_data), 32'(ew[7:0]));
        end
        checkOutput("reqDuringWrite", 32'(bus.int_req), 1);
        if (latChk) checkOutput("writeGrantLatency", reqRun, 2);
        if (prevWr) reportFail("writeTwoCycles", 1, 0);
      end
      if (bus.int_read) begin
        rdSeen++;
        if (expRdAddr.size() == 0) reportFail("unexpectedRead", 32'(bus.int_address), 0);
        else checkOutput("readAddr", 32'(bus.int_address), 32'(expRdAddr.pop_front()));
        bus.int_rd_data = (rdData.size() > 0) ? rdData.pop_front() : 8'h00;
        checkOutput("reqDuringRead", 32'(bus.int_req), 1);
        if (latChk) checkOutput("readGrantLatency", reqRun, 2);
        if (prevRd) reportFail("readTwoCycles", 1, 0);
      end
      if (bus.int_write && bus.int_read) reportFail("writeAndRead", 1, 0);
      if (bus.new_tx_data) begin
        txSeen++;
        if (expTx.size() == 0) reportFail("unexpectedTx", 32'(bus.tx_data), 0);
        else checkOutput("txData", 32'(bus.tx_data), 32'(expTx.pop_front()));
        checkOutput("txAfterBusyLow", 32'(bus.tx_busy), 0);
        if (prevTx) reportFail("txTwoCycles", 1, 0);
      end
      if (bus.rx_overrun) begin
        ovrSeen++;
        if (expOvr == 0) reportFail("unexpectedOverrun", 1, 0);
        else begin
          checks++;
          expOvr--;
        end
        if (prevOvr) reportFail("overrunTwoCycles", 1, 0);
      end
      prevWr = bus.int_write; prevRd = bus.int_read;
      prevTx = bus.new_tx_data; prevOvr = bus.rx_overrun;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    bus.rx_data = b;
    bus.new_rx_data = 1'b1;
    @(negedge clock);
    bus.new_rx_data = 1'b0;
    bus.rx_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic waitWrites(input int target);
    int n = 0;
    while (wrSeen < target && n < 2000) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (wrSeen < target) reportFail("writeTimeout", wrSeen, target);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expWr.size() + expTx.size() + expRdAddr.size() + expOvr) > 0 && n < budget) begin
      @(posedge clock);
      #2;
      n++;
    end
    if ((expWr.size() + expTx.size() + expRdAddr.size() + expOvr) > 0) begin
      reportFail("drainTimeout", expWr.size() + expTx.size() + expRdAddr.size() + expOvr, 0);
      expWr.delete(); expTx.delete(); expRdAddr.delete(); rdData.delete(); expOvr = 0;
    end
    repeat (3) @(posedge clock);
    #2;
  endtask

  // Reference model: expand a frame into the bus accesses and UART bytes it implies
  task automatic runFrame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] lenByte, input int gm);
    int n;
    int base;
    logic [7:0] d;
    logic [7:0] wd[$];
    n = (lenByte == 8'd0) ? 256 : int'(lenByte);
    gntMode = gm;
    latChk = (gm == 0);
    for (int i = 0; i < n; i++) begin
      d = (fixedQ.size() > 0) ? fixedQ.pop_front() : 8'($urandom);
      if (cmd == 8'h02) begin
        expWr.push_back({addr + 16'(i), d});
        wd.push_back(d);
        totWr++;
      end else begin
        expRdAddr.push_back(addr + 16'(i));
        rdData.push_back(d);
        expTx.push_back(d);
        totRd++;
        totTx++;
      end
    end
    if (cmd == 8'h02) begin
      expTx.push_back(ACK);
      totTx++;
    end
    applyStimulus(cmd);
    applyStimulus(addr[15:8]);
    applyStimulus(addr[7:0]);
    applyStimulus(lenByte);
    if (cmd == 8'h02) begin
      foreach (wd[i]) begin
        base = wrSeen;
        applyStimulus(wd[i]);
        waitWrites(base + 1);
        @(posedge clock);
      end
    end
    waitDrain(20000);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstAddress", 32'(bus.int_address), 0);
    checkOutput("rstWrData", 32'(bus.int_wr_data), 0);
    checkOutput("rstTxData", 32'(bus.tx_data), 0);
    checkOutput("rstReq", 32'(bus.int_req), 0);
    checkOutput("rstWrite", 32'(bus.int_write), 0);
    checkOutput("rstRead", 32'(bus.int_read), 0);
    checkOutput("rstNewTx", 32'(bus.new_tx_data), 0);
    checkOutput("rstOverrun", 32'(bus.rx_overrun), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ov0;
    int rd0;
    logic [7:0] cmd;
    logic [15:0] addr;
    bus.rx_data = 8'h00;
    bus.new_rx_data = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs();
    @(negedge clock);
    reset = 1'b0;

    fixedQ.push_back(8'hAA); fixedQ.push_back(8'hBB);
    runFrame(8'h02, 16'h1234, 8'h02, 0);

    fixedQ.push_back(8'h11); fixedQ.push_back(8'h22);
    runFrame(8'h01, 16'hFFFF, 8'h02, 0);

    rd0 = rdSeen;
    runFrame(8'h01, 16'h0000, 8'h00, 0);
    checkOutput("len0ReadCount", rdSeen - rd0, 256);

    // Grant withheld for ten cycles while the read request is pending
    gntMode = 2;
    latChk = 1'b0;
    expRdAddr.push_back(16'h0040); rdData.push_back(8'h3C); expTx.push_back(8'h3C);
    totRd++; totTx++;
    applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h40); applyStimulus(8'h01);
    rd0 = rdSeen;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #2;
      checkOutput("reqHeldNoGrant", 32'(bus.int_req), 1);
      checkOutput("noStrobeNoGrant", 32'(bus.int_read), 0);
    end
    gntMode = 0;
    @(posedge clock);
    #2;
    checkOutput("strobeAfterGrant", 32'(bus.int_read), 1);
    waitDrain(2000);
    checkOutput("grantReadCount", rdSeen - rd0, 1);

    // Junk byte in IDLE is ignored without an overrun
    ov0 = ovrSeen;
    applyStimulus(8'h55);
    repeat (4) @(posedge clock);
    #2;
    checkOutput("idleJunkNoOverrun", ovrSeen - ov0, 0);

    // Byte arriving while waiting on the transmitter is dropped
    busyForce = 1'b1;
    fixedQ.push_back(8'h99);
    expWr.push_back({16'h2000, 8'h99}); expTx.push_back(ACK);
    totWr++; totTx++;
    fixedQ.delete();
    gntMode = 0; latChk = 1'b1;
    applyStimulus(8'h02); applyStimulus(8'h20); applyStimulus(8'h00); applyStimulus(8'h01);
    applyStimulus(8'h99);
    waitWrites(wrSeen + ((expWr.size() > 0) ? 1 : 0));
    repeat (3) @(posedge clock);
    ov0 = ovrSeen;
    expOvr = 1;
    applyStimulus(8'h77);
    repeat (2) @(posedge clock);
    #2;
    checkOutput("overrunPulse", ovrSeen - ov0, 1);
    busyForce = 1'b0;
    waitDrain(2000);

    // Reset mid-frame, then a fresh frame must decode from its CMD byte
    gntMode = 0;
    applyStimulus(8'h02); applyStimulus(8'hAB); applyStimulus(8'hCD);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #2;
    checkResetOutputs();
    @(negedge clock);
    reset = 1'b0;
    fixedQ.push_back(8'hCC);
    runFrame(8'h02, 16'h0010, 8'h01, 0);

    for (int k = 0; k < 10; k++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      runFrame(cmd, addr, 8'($urandom_range(1, 5)), $urandom_range(0, 1));
    end

    checkOutput("totalWrites", wrSeen, totWr);
    checkOutput("totalReads", rdSeen, totRd);
    checkOutput("totalTx", txSeen, totTx);
    checkOutput("totalOverruns", ovrSeen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
